// File: rtl/rhs2116_spi_responder_pkg.sv
// Shared constants and types for the RHS2116 SPI responder: opcodes, command
// field positions, the write acknowledge prefix and the responder FSM states.
package rhs2116_pkg;

  typedef enum logic [1:0] {
    OP_CONVERT = 2'b00,
    OP_CLEAR   = 2'b01,
    OP_WRITE   = 2'b10,
    OP_READ    = 2'b11
  } opcode_e;

  localparam int FRAME_BITS = 32;
  localparam int OP_MSB     = 31;
  localparam int OP_LSB     = 30;
  localparam int ADDR_MSB   = 23;
  localparam int ADDR_LSB   = 16;
  localparam int CH_MSB     = 21;
  localparam int CH_LSB     = 16;
  localparam int DATA_MSB   = 15;
  localparam int DATA_LSB   = 0;

  localparam logic [15:0] WRITE_ACK = 16'hFFFF;

  typedef enum logic [2:0] {
    ARM,
    IDLE,
    SHIFT,
    COMMIT,
    CAPTURE
  } state_e;

endpackage

// File: rtl/rhs2116_spi_responder_if.sv
// Four-wire SPI link between the link encoder (master) and a sensor (slave).
interface rhs2116_spi_responder_if;
  logic cs_n;
  logic sclk;
  logic mosi;
  logic miso;

  modport master (output cs_n, output sclk, output mosi, input miso);
  modport slave  (input cs_n, input sclk, input mosi, output miso);
endinterface

// File: rtl/rhs2116_spi_responder_spi_in_sync.sv
// Two-flop synchronizer for cs_n/sclk/mosi with rise/fall strobes on the synced
// sclk. Idle levels at reset: cs_n high, sclk low, mosi low.
module spi_in_sync (
  input  logic clk,
  input  logic rst,
  input  logic cs_n,
  input  logic sclk,
  input  logic mosi,
  output logic cs_n_s,
  output logic mosi_s,
  output logic sclk_rise,
  output logic sclk_fall
);

  logic [2:0] meta;
  logic [2:0] sync;
  logic       sclk_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta   <= 3'b100;
      sync   <= 3'b100;
      sclk_d <= 1'b0;
    end else begin
      meta   <= {cs_n, sclk, mosi};
      sync   <= meta;
      sclk_d <= sync[1];
    end
  end

  assign cs_n_s    = sync[2];
  assign mosi_s    = sync[0];
  assign sclk_rise = sync[1] & ~sclk_d;
  assign sclk_fall = ~sync[1] & sclk_d;

endmodule

// File: rtl/rhs2116_spi_responder.sv
// SPI slave emulating the RHS2116 sensor side: decodes 32-bit commands, keeps a
// small register file and returns each command's response two frames later.
module rhs2116_spi_responder
  import rhs2116_pkg::*;
#(
  parameter int          NUM_REGS  = 16,
  parameter logic [15:0] RESET_VAL = 16'h0000
) (
  input  logic                     clk_sys,
  input  logic                     rst,
  rhs2116_spi_responder_if.slave   spi,
  output logic                     sample_req,
  output logic [5:0]               sample_ch,
  input  logic [31:0]              sample_data,
  output logic                     frame_done,
  output logic                     frame_error,
  output logic [31:0]              cmd_word
);

  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  state_e      state, state_next;
  logic        cs_n_s, mosi_s, sclk_rise, sclk_fall;
  logic [5:0]  bit_cnt;
  logic [1:0]  arm_cnt;
  logic [31:0] rx_shift, tx_shift;
  logic [31:0] resp_q1, resp_q2;
  logic [31:0] resp;
  logic [15:0] regs [NUM_REGS];
  opcode_e     op;
  logic [7:0]  addr;
  logic [AW-1:0] idx;
  logic        addr_ok;
  logic        frame_full;

  spi_in_sync u_sync (
    .clk       (clk_sys),
    .rst       (rst),
    .cs_n      (spi.cs_n),
    .sclk      (spi.sclk),
    .mosi      (spi.mosi),
    .cs_n_s    (cs_n_s),
    .mosi_s    (mosi_s),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall)
  );

  assign op         = opcode_e'(rx_shift[OP_MSB:OP_LSB]);
  assign addr       = rx_shift[ADDR_MSB:ADDR_LSB];
  assign idx        = addr[AW-1:0];
  assign addr_ok    = ({24'd0, addr} < NUM_REGS);
  assign frame_full = (bit_cnt == 6'(FRAME_BITS));

  always_comb begin
    resp = 32'h0;
    case (op)
      OP_WRITE: resp = {WRITE_ACK, rx_shift[DATA_MSB:DATA_LSB]};
      OP_READ:  resp = addr_ok ? {16'h0000, regs[idx]} : 32'h0;
      default:  resp = 32'h0;
    endcase
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) state <= ARM;
    else     state <= state_next;
  end

  // ARM needs a few real high samples of cs_n, since the synchronizer itself
  // resets to high and would otherwise hide a cs_n held low through reset.
  always_comb begin
    state_next  = state;
    frame_done  = 1'b0;
    frame_error = 1'b0;
    sample_req  = 1'b0;
    spi.miso    = 1'b0;
    case (state)
      ARM:     if (arm_cnt == 2'd3) state_next = IDLE;
      IDLE:    if (!cs_n_s) state_next = SHIFT;
      SHIFT: begin
        spi.miso = tx_shift[31];
        if (cs_n_s) begin
          state_next  = frame_full ? COMMIT : IDLE;
          frame_error = !frame_full;
        end
      end
      COMMIT: begin
        frame_done = 1'b1;
        sample_req = (op == OP_CONVERT);
        state_next = (op == OP_CONVERT) ? CAPTURE : IDLE;
      end
      CAPTURE: state_next = IDLE;
      default: state_next = ARM;
    endcase
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      arm_cnt   <= 2'd0;
      bit_cnt   <= 6'd0;
      rx_shift  <= 32'h0;
      tx_shift  <= 32'h0;
      resp_q1   <= 32'h0;
      resp_q2   <= 32'h0;
      cmd_word  <= 32'h0;
      sample_ch <= 6'd0;
    end else begin
      if (state == ARM)
        arm_cnt <= cs_n_s ? ((arm_cnt == 2'd3) ? arm_cnt : arm_cnt + 2'd1) : 2'd0;
      else
        arm_cnt <= 2'd0;
      case (state)
        IDLE: begin
          if (!cs_n_s) begin
            bit_cnt  <= 6'd0;
            tx_shift <= resp_q2;
          end
        end
        SHIFT: begin
          if (cs_n_s) begin
            if (frame_full) begin
              cmd_word <= rx_shift;
              if (op == OP_CONVERT) sample_ch <= rx_shift[CH_MSB:CH_LSB];
            end
          end else begin
            if (sclk_rise) begin
              rx_shift <= {rx_shift[30:0], mosi_s};
              if (bit_cnt != 6'd33) bit_cnt <= bit_cnt + 6'd1;
            end
            if (sclk_fall) tx_shift <= {tx_shift[30:0], 1'b0};
          end
        end
        COMMIT: begin
          resp_q2 <= resp_q1;
          if (op != OP_CONVERT) resp_q1 <= resp;
        end
        CAPTURE: resp_q1 <= sample_data;
        default: ;
      endcase
    end
  end

  // Register file updates land in COMMIT, after the READ response was formed.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
    end else if (state == COMMIT) begin
      if (op == OP_CLEAR) begin
        for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
      end else if (op == OP_WRITE && addr_ok) begin
        regs[idx] <= rx_shift[DATA_MSB:DATA_LSB];
      end
    end
  end

endmodule

// File: tb/tb_rhs2116_spi_responder.sv
// Directed bench for the RHS2116 SPI responder: drives SPI frames as a mode-0
// master and compares miso words, pulse counts and cmd_word with hand values.
module tb_rhs2116_spi_responder;

  localparam int H = 8;

  logic        clk_sys = 1'b0;
  logic        rst;
  logic        sample_req;
  logic [5:0]  sample_ch;
  logic [31:0] sample_data;
  logic        frame_done;
  logic        frame_error;
  logic [31:0] cmd_word;

  int          checks = 0;
  int          failures = 0;
  int          done_cnt = 0;
  int          err_cnt = 0;
  int          req_cnt = 0;
  logic [5:0]  req_ch = 6'd0;

  rhs2116_spi_responder_if spi ();

  rhs2116_spi_responder dut (
    .clk_sys     (clk_sys),
    .rst         (rst),
    .spi         (spi),
    .sample_req  (sample_req),
    .sample_ch   (sample_ch),
    .sample_data (sample_data),
    .frame_done  (frame_done),
    .frame_error (frame_error),
    .cmd_word    (cmd_word)
  );

  always #5 clk_sys = ~clk_sys;

  always @(negedge clk_sys) begin
    if (frame_done)  done_cnt++;
    if (frame_error) err_cnt++;
    if (sample_req) begin
      req_cnt++;
      req_ch = sample_ch;
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  // Sends the low nbits of bits MSB first; rx_word holds the last 32 miso bits.
  task automatic spi_frame(input logic [63:0] bits, input int nbits, output logic [31:0] rx_word);
    rx_word  = 32'h0;
    spi.cs_n = 1'b0;
    for (int i = nbits - 1; i >= 0; i--) begin
      spi.mosi = bits[i];
      wait_clks(H);
      rx_word  = {rx_word[30:0], spi.miso};
      spi.sclk = 1'b1;
      wait_clks(H);
      spi.sclk = 1'b0;
    end
    spi.mosi = 1'b0;
    wait_clks(H);
    spi.cs_n = 1'b1;
    wait_clks(16);
  endtask

  task automatic test_reset;
    rst         = 1'b1;
    spi.cs_n    = 1'b1;
    spi.sclk    = 1'b0;
    spi.mosi    = 1'b0;
    sample_data = 32'h0;
    wait_clks(4);
    checks++;
    if ({spi.miso, sample_req, frame_done, frame_error} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_pulses got %b exp 0000", {spi.miso, sample_req, frame_done, frame_error});
    end
    checks++;
    if (cmd_word !== 32'h0 || sample_ch !== 6'd0) begin
      failures++;
      $display("FAIL reset_regs cmd_word %h sample_ch %0d exp 0 0", cmd_word, sample_ch);
    end
    rst = 1'b0;
    wait_clks(8);
    checks++;
    if (spi.miso !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle_miso got %b exp 0", spi.miso);
    end
  endtask

  task automatic test_write_read;
    logic [31:0] cmds [4];
    logic [31:0] exp  [4];
    logic [31:0] rx;
    int d0;
    cmds = '{32'h8003_BEEF, 32'hC003_0000, 32'hC003_0000, 32'hC003_0000};
    exp  = '{32'h0, 32'h0, 32'hFFFF_BEEF, 32'h0000_BEEF};
    d0 = done_cnt;
    for (int i = 0; i < 4; i++) begin
      spi_frame({32'h0, cmds[i]}, 32, rx);
      checks++;
      if (rx !== exp[i]) begin
        failures++;
        $display("FAIL write_read_miso[%0d] got %h exp %h", i, rx, exp[i]);
      end
      checks++;
      if (cmd_word !== cmds[i]) begin
        failures++;
        $display("FAIL write_read_cmd[%0d] got %h exp %h", i, cmd_word, cmds[i]);
      end
    end
    checks++;
    if (done_cnt !== d0 + 4) begin
      failures++;
      $display("FAIL write_read_done got %0d exp %0d", done_cnt - d0, 4);
    end
  endtask

  task automatic test_convert;
    logic [31:0] cmds [3];
    logic [31:0] exp  [3];
    logic [31:0] rx;
    int r0;
    cmds = '{32'h0005_0000, 32'hC000_0000, 32'hC000_0000};
    exp  = '{32'h0000_BEEF, 32'h0000_BEEF, 32'h1234_5678};
    sample_data = 32'h1234_5678;
    r0 = req_cnt;
    for (int i = 0; i < 3; i++) begin
      spi_frame({32'h0, cmds[i]}, 32, rx);
      checks++;
      if (rx !== exp[i]) begin
        failures++;
        $display("FAIL convert_miso[%0d] got %h exp %h", i, rx, exp[i]);
      end
    end
    checks++;
    if (req_cnt !== r0 + 1 || req_ch !== 6'd5) begin
      failures++;
      $display("FAIL convert_req count %0d ch %0d exp 1 5", req_cnt - r0, req_ch);
    end
    checks++;
    if (sample_ch !== 6'd5) begin
      failures++;
      $display("FAIL convert_ch_hold got %0d exp 5", sample_ch);
    end
  endtask

  task automatic test_short_frame;
    logic [31:0] rx;
    int d0, e0;
    spi_frame({32'h0, 32'h8005_1111}, 32, rx);
    spi_frame({32'h0, 32'h8006_2222}, 32, rx);
    d0 = done_cnt;
    e0 = err_cnt;
    spi_frame(64'h0000_0000_6002_8000, 31, rx);
    checks++;
    if (err_cnt !== e0 + 1 || done_cnt !== d0) begin
      failures++;
      $display("FAIL short_pulses err %0d done %0d exp 1 0", err_cnt - e0, done_cnt - d0);
    end
    checks++;
    if (cmd_word !== 32'h8006_2222) begin
      failures++;
      $display("FAIL short_cmd got %h exp %h", cmd_word, 32'h8006_2222);
    end
    spi_frame({32'h0, 32'hC005_0000}, 32, rx);
    checks++;
    if (rx !== 32'hFFFF_1111) begin
      failures++;
      $display("FAIL short_after1 got %h exp %h", rx, 32'hFFFF_1111);
    end
    spi_frame({32'h0, 32'hC006_0000}, 32, rx);
    checks++;
    if (rx !== 32'hFFFF_2222) begin
      failures++;
      $display("FAIL short_after2 got %h exp %h", rx, 32'hFFFF_2222);
    end
  endtask

  task automatic test_long_frame;
    logic [31:0] cmds [3];
    logic [31:0] exp  [3];
    logic [31:0] rx;
    int d0, e0;
    cmds = '{32'hC007_0000, 32'hC000_0000, 32'hC000_0000};
    exp  = '{32'h0000_1111, 32'h0000_2222, 32'h0000_0000};
    d0 = done_cnt;
    e0 = err_cnt;
    spi_frame(64'h0000_0001_000E_EEEE, 33, rx);
    checks++;
    if (err_cnt !== e0 + 1 || done_cnt !== d0) begin
      failures++;
      $display("FAIL long_pulses err %0d done %0d exp 1 0", err_cnt - e0, done_cnt - d0);
    end
    for (int i = 0; i < 3; i++) begin
      spi_frame({32'h0, cmds[i]}, 32, rx);
      checks++;
      if (rx !== exp[i]) begin
        failures++;
        $display("FAIL long_miso[%0d] got %h exp %h", i, rx, exp[i]);
      end
    end
  endtask

  task automatic test_clear;
    logic [31:0] cmds [5];
    logic [31:0] exp  [5];
    logic [31:0] rx;
    cmds = '{32'h8002_00AA, 32'h4000_0000, 32'hC002_0000, 32'hC000_0000, 32'hC000_0000};
    exp  = '{32'h0, 32'h0, 32'hFFFF_00AA, 32'h0, 32'h0};
    for (int i = 0; i < 5; i++) begin
      spi_frame({32'h0, cmds[i]}, 32, rx);
      checks++;
      if (rx !== exp[i]) begin
        failures++;
        $display("FAIL clear_miso[%0d] got %h exp %h", i, rx, exp[i]);
      end
    end
  endtask

  task automatic test_out_of_range;
    logic [31:0] cmds [5];
    logic [31:0] exp  [5];
    logic [31:0] rx;
    cmds = '{32'h8028_1234, 32'hC028_0000, 32'hC008_0000, 32'hC000_0000, 32'hC000_0000};
    exp  = '{32'h0, 32'h0, 32'hFFFF_1234, 32'h0, 32'h0};
    for (int i = 0; i < 5; i++) begin
      spi_frame({32'h0, cmds[i]}, 32, rx);
      checks++;
      if (rx !== exp[i]) begin
        failures++;
        $display("FAIL oor_miso[%0d] got %h exp %h", i, rx, exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [31:0] rx;
    logic [31:0] partial;
    int d0, e0;
    spi_frame({32'h0, 32'h8009_5A5A}, 32, rx);
    spi_frame({32'h0, 32'h800A_A5A5}, 32, rx);
    partial  = 32'hC003_0000;
    d0       = done_cnt;
    e0       = err_cnt;
    spi.cs_n = 1'b0;
    for (int i = 31; i > 16; i--) begin
      spi.mosi = partial[i];
      wait_clks(H);
      spi.sclk = 1'b1;
      wait_clks(H);
      spi.sclk = 1'b0;
    end
    rst = 1'b1;
    wait_clks(3);
    rst = 1'b0;
    wait_clks(8);
    spi.cs_n = 1'b1;
    wait_clks(16);
    checks++;
    if (err_cnt !== e0 || done_cnt !== d0) begin
      failures++;
      $display("FAIL midreset_pulses err %0d done %0d exp 0 0", err_cnt - e0, done_cnt - d0);
    end
    checks++;
    if (cmd_word !== 32'h0) begin
      failures++;
      $display("FAIL midreset_cmd got %h exp 0", cmd_word);
    end
    spi_frame({32'h0, 32'hC000_0000}, 32, rx);
    checks++;
    if (rx !== 32'h0 || done_cnt !== d0 + 1) begin
      failures++;
      $display("FAIL midreset_next miso %h done %0d exp 0 1", rx, done_cnt - d0);
    end
    checks++;
    if (cmd_word !== 32'hC000_0000) begin
      failures++;
      $display("FAIL midreset_next_cmd got %h exp %h", cmd_word, 32'hC000_0000);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_convert();
    test_short_frame();
    test_long_frame();
    test_clear();
    test_out_of_range();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
